trap_unit: RTL and testbench

//  Machine-mode trap/CSR stage directly downstream of the instruction control decoder.

---
 rtl/trap_if.sv | 27 ++
 rtl/trap_unit.sv | 74 +++++++
 tb/tb_trap_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/trap_if.sv
// trap_if: decoder-to-trap-unit bundle carrying instruction flags, CSR access and PC redirect
interface trap_if;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ecall;
    logic        ebreak;
    logic        illegalinst;
    logic        mret;
    logic        csrwen;
    logic [11:0] csraddr;
    logic [31:0] csrwdata;
    logic        irq;
    logic [31:0] csrrdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mie;
    modport master (
        output inst_valid, pc, inst, ecall, ebreak, illegalinst, mret, csrwen, csraddr, csrwdata, irq,
        input  csrrdata, stall, redirect, redirect_pc, mie
    );
    modport slave (
        input  inst_valid, pc, inst, ecall, ebreak, illegalinst, mret, csrwen, csraddr, csrwdata, irq,
        output csrrdata, stall, redirect, redirect_pc, mie
    );
endinterface

// File: rtl/trap_unit.sv
// trap_unit: machine-mode CSRs, 2-cycle trap entry sequencing and MRET/trap PC redirect
module trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit          IRQ_EN      = 1'b1
) (
    input logic   clk,
    input logic   rst_n,
    trap_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENTER, VECTOR} state_t;
    state_t      state, state_nx;
    logic        mstatus_mie, mpie, meie, act, irq_take, trap, do_mret, do_wr;
    logic [31:0] mtvec, mscratch, mepc, mcause, mtval, cause_nx, tval_nx, mstatus;
    always_comb begin
        act = state == IDLE && bus.inst_valid;
        irq_take = act && IRQ_EN && bus.irq && mstatus_mie && meie;
        trap = irq_take || (act && (bus.illegalinst || bus.ebreak || bus.ecall));
        do_mret = act && !trap && bus.mret;
        do_wr = act && !trap && bus.csrwen;
        cause_nx = irq_take ? 32'h8000_000B : bus.illegalinst ? 32'd2 : bus.ebreak ? 32'd3 : 32'd11;
        tval_nx = irq_take ? 32'd0 : bus.illegalinst ? bus.inst : bus.ebreak ? bus.pc : 32'd0;
        state_nx = state == IDLE ? (trap ? ENTER : IDLE) : state == ENTER ? VECTOR : IDLE;
        mstatus = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mstatus_mie, 3'd0};
        bus.csrrdata = bus.csraddr == 12'h300 ? mstatus :
                       bus.csraddr == 12'h304 ? {20'd0, meie, 11'd0} :
                       bus.csraddr == 12'h305 ? mtvec :
                       bus.csraddr == 12'h340 ? mscratch :
                       bus.csraddr == 12'h341 ? mepc :
                       bus.csraddr == 12'h342 ? mcause :
                       bus.csraddr == 12'h343 ? mtval : 32'd0;
        // outputs are gated by reset so they drop the moment rst_n falls
        bus.stall = rst_n && (state == ENTER || trap);
        bus.redirect = rst_n && (state == VECTOR || do_mret);
        bus.redirect_pc = !bus.redirect ? 32'd0 : state == VECTOR ? mtvec : mepc;
        bus.mie = mstatus_mie;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mtvec <= {MTVEC_RESET[31:2], 2'b00};
            mstatus_mie <= 1'b0;
            mpie <= 1'b0;
            meie <= 1'b0;
            mscratch <= 32'd0;
            mepc <= 32'd0;
            mcause <= 32'd0;
            mtval <= 32'd0;
        end else begin
            state <= state_nx;
            if (do_wr)
                case (bus.csraddr)
                    12'h300: begin mstatus_mie <= bus.csrwdata[3]; mpie <= bus.csrwdata[7]; end
                    12'h304: meie <= bus.csrwdata[11];
                    12'h305: mtvec <= {bus.csrwdata[31:2], 2'b00};
                    12'h340: mscratch <= bus.csrwdata;
                    12'h341: mepc <= {bus.csrwdata[31:2], 2'b00};
                    12'h342: mcause <= bus.csrwdata;
                    12'h343: mtval <= bus.csrwdata;
                    default: ;
                endcase
            if (do_mret) begin
                mstatus_mie <= mpie;
                mpie <= 1'b1;
            end
            if (trap) begin
                mepc <= {bus.pc[31:2], 2'b00};
                mcause <= cause_nx;
                mtval <= tval_nx;
                mpie <= mstatus_mie;
                mstatus_mie <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: randomized scoreboard bench comparing trap_unit against an architectural CSR model
module tb_trap_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    trap_if bus();
    trap_unit #(.MTVEC_RESET(32'h0000_0100), .IRQ_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct packed {logic stall; logic redirect; logic [31:0] rpc; logic [31:0] rdata; logic mie;} exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    logic m_mie, m_mpie, m_meie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    int m_pend;
    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask
    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_mtvec = 32'h100;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_pend = 0;
    endtask
    function automatic logic [31:0] m_read(logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return 32'(m_meie) << 11;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 0;
        endcase
    endfunction
    task automatic m_write(logic [11:0] a, logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h304: m_meie = d[11];
            12'h305: m_mtvec = d & ~32'h3;
            12'h340: m_mscratch = d;
            12'h341: m_mepc = d & ~32'h3;
            12'h342: m_mcause = d;
            12'h343: m_mtval = d;
            default: ;
        endcase
    endtask
    task automatic step();
        exp_t e;
        logic irq;
        e = '0;
        if (!rst_n) begin
            m_reset();
            e.rdata = m_read(bus.csraddr);
            q.push_back(e);
            return;
        end
        e.rdata = m_read(bus.csraddr);
        e.mie = m_mie;
        if (m_pend == 2) begin
            e.stall = 1; m_pend = 1;
        end else if (m_pend == 1) begin
            e.redirect = 1; e.rpc = m_mtvec; m_pend = 0;
        end else if (bus.inst_valid) begin
            irq = bus.irq && m_mie && m_meie;
            if (irq || bus.illegalinst || bus.ebreak || bus.ecall) begin
                e.stall = 1;
                m_mepc = bus.pc & ~32'h3;
                m_mcause = irq ? 32'h8000_000B : bus.illegalinst ? 2 : bus.ebreak ? 3 : 11;
                m_mtval = irq ? 0 : bus.illegalinst ? bus.inst : bus.ebreak ? bus.pc : 0;
                m_mpie = m_mie; m_mie = 0; m_pend = 2;
            end else begin
                if (bus.csrwen) m_write(bus.csraddr, bus.csrwdata);
                if (bus.mret) begin
                    e.redirect = 1; e.rpc = m_mepc; m_mie = m_mpie; m_mpie = 1;
                end
            end
        end
        q.push_back(e);
    endtask
    task automatic drive(logic v, logic [31:0] pc, logic [31:0] inst, logic ec, logic eb, logic il,
                         logic mr, logic wen, logic [11:0] a, logic [31:0] wd, logic irq);
        bus.inst_valid = v; bus.pc = pc; bus.inst = inst; bus.ecall = ec; bus.ebreak = eb;
        bus.illegalinst = il; bus.mret = mr; bus.csrwen = wen; bus.csraddr = a; bus.csrwdata = wd; bus.irq = irq;
    endtask
    task automatic cyc();
        step();
        @(posedge clk);
        #1;
    endtask
    task automatic peek(logic [11:0] a, logic [31:0] e, string nm);
        drive(0, 0, 0, 0, 0, 0, 0, 0, a, 0, 0);
        #1 chk(nm, bus.csrrdata, e);
        cyc();
    endtask
    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h342, 0, 0); cyc(); end
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(bus.stall), 32'(e.stall));
                chk("redirect", 32'(bus.redirect), 32'(e.redirect));
                chk("redirect_pc", bus.redirect_pc, e.rpc);
                chk("csrrdata", bus.csrrdata, e.rdata);
                chk("mie", 32'(bus.mie), 32'(e.mie));
            end
        end
    end
    initial begin : stim
        logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7c0};
        logic mr;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h305, 0, 0);
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        peek(12'h305, 32'h0000_0100, "rst_mtvec");
        peek(12'h300, 32'h0000_1800, "rst_mstatus");
        drive(1, 32'h40, 32'h73, 1, 0, 0, 0, 0, 12'h300, 0, 0); cyc();
        idle(2);
        peek(12'h341, 32'h40, "ecall_mepc");
        peek(12'h342, 32'd11, "ecall_mcause");
        drive(1, 32'h44, 0, 0, 0, 0, 0, 1, 12'h300, 32'h8, 0); cyc();
        drive(1, 32'h48, 0, 0, 0, 0, 0, 1, 12'h304, 32'h800, 0); cyc();
        drive(1, 32'h80, 0, 0, 0, 0, 0, 0, 12'h300, 0, 1); cyc();
        idle(2);
        peek(12'h342, 32'h8000_000B, "irq_mcause");
        drive(1, 32'h100, 32'h30200073, 0, 0, 0, 1, 0, 12'h341, 0, 0); cyc();
        drive(1, 32'h10, 32'hFFFF_FFFF, 0, 1, 1, 0, 1, 12'h340, 32'hAA, 0); cyc();
        idle(2);
        peek(12'h343, 32'hFFFF_FFFF, "illegal_mtval");
        peek(12'h340, 32'h0, "illegal_mscratch");
        drive(1, 32'h20, 0, 0, 0, 0, 0, 1, 12'h305, 32'h203, 0); cyc();
        peek(12'h305, 32'h200, "mtvec_align");
        drive(1, 32'h24, 0, 0, 1, 0, 0, 0, 12'h305, 0, 0); cyc();
        idle(2);
        peek(12'h343, 32'h24, "ebreak_mtval");
        drive(1, 32'h50, 0, 1, 0, 0, 0, 0, 12'h342, 0, 0); cyc();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h305, 0, 0);
        #1 chk("rst_enter_stall", 32'(bus.stall), 32'd0);
        cyc();
        rst_n = 1'b1;
        idle(3);
        drive(0, 32'h60, 0, 1, 0, 0, 0, 0, 12'h300, 0, 0);
        #1 chk("novalid_stall", 32'(bus.stall), 32'd0);
        cyc();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            mr = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, mr,
                  !mr && $urandom_range(0, 2) == 0, addrs[$urandom_range(0, 7)], $urandom,
                  $urandom_range(0, 3) == 0);
            cyc();
        end
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
